// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared ALU.
// A request is granted in IDLE and its operands are registered onto the ALU.
// The ALU result and zero flag are captured one cycle later, then held until
// the owning requester accepts the response. When both requesters are
// waiting, a round-robin pointer decides which one is granted.
module alu_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           n_reset,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*N-1:0] req_a,
    input  logic [2*N-1:0] req_b,
    input  logic [5:0]     req_func,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [2:0]     alu_func,
    input  logic [N-1:0]   alu_result,
    input  logic           alu_zf,
    output logic [1:0]     rsp_valid,
    input  logic [1:0]     rsp_ready,
    output logic [N-1:0]   rsp_result,
    output logic           rsp_zf,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic           owner_reg, owner_next;
    logic           ptr_reg, ptr_next;
    logic [N-1:0]   alu_a_reg, alu_a_next;
    logic [N-1:0]   alu_b_reg, alu_b_next;
    logic [2:0]     alu_func_reg, alu_func_next;
    logic [N-1:0]   rsp_result_reg, rsp_result_next;
    logic           rsp_zf_reg, rsp_zf_next;
    logic [1:0]     req_ready_c;
    logic [1:0]     rsp_valid_c;
    logic           grant_valid;
    logic           grant_id;

    // The packed request buses, split into one entry per requester
    logic [N-1:0]   req_a_arr    [2];
    logic [N-1:0]   req_b_arr    [2];
    logic [2:0]     req_func_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign req_a_arr[gi]    = req_a[gi*N +: N];
            assign req_b_arr[gi]    = req_b[gi*N +: N];
            assign req_func_arr[gi] = req_func[gi*3 +: 3];
        end
    endgenerate

    // Choose which requester is granted: a lone requester always wins;
    // when both ask, the round-robin pointer decides.
    // Gating with n_reset keeps req_ready low for the whole time reset is held.
    always_comb begin
        grant_valid = (|req_valid) & n_reset;
        grant_id    = 1'b0;
        if (req_valid == 2'b11) begin
            grant_id = ptr_reg;
        end else begin
            grant_id = req_valid[1];
        end
    end

    // Next-state logic, the request/response handshakes and operand capture
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        ptr_next        = ptr_reg;
        alu_a_next      = alu_a_reg;
        alu_b_next      = alu_b_reg;
        alu_func_next   = alu_func_reg;
        rsp_result_next = rsp_result_reg;
        rsp_zf_next     = rsp_zf_reg;
        req_ready_c     = 2'b00;
        rsp_valid_c     = 2'b00;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    req_ready_c[grant_id] = 1'b1;
                    owner_next            = grant_id;
                    alu_a_next            = req_a_arr[grant_id];
                    alu_b_next            = req_b_arr[grant_id];
                    alu_func_next         = req_func_arr[grant_id];
                    state_next            = EXEC;
                end
            end
            EXEC: begin
                rsp_result_next = alu_result;
                rsp_zf_next     = alu_zf;
                state_next      = RESP;
            end
            RESP: begin
                rsp_valid_c[owner_reg] = 1'b1;
                // Only the owner's rsp_ready completes the response
                if (rsp_ready[owner_reg]) begin
                    ptr_next   = ~owner_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, operand and response registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            ptr_reg        <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_func_reg   <= '0;
            rsp_result_reg <= '0;
            rsp_zf_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            ptr_reg        <= ptr_next;
            alu_a_reg      <= alu_a_next;
            alu_b_reg      <= alu_b_next;
            alu_func_reg   <= alu_func_next;
            rsp_result_reg <= rsp_result_next;
            rsp_zf_reg     <= rsp_zf_next;
        end
    end

    assign req_ready  = req_ready_c;
    assign rsp_valid  = rsp_valid_c;
    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_func   = alu_func_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zf     = rsp_zf_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N, default 8, operand and result width in bits; SHALL match the shared alu instance.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 n_reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  bit i = requester i presents an operation.
REQ-005 req_ready  output  2  bit i = operation of requester i accepted this cycle.
REQ-006 req_a  input  2N  requester i operand A at bits [i*N +: N].
REQ-007 req_b  input  2N  requester i operand B at bits [i*N +: N].
REQ-008 req_func  input  6  requester i ALU function code (alucodes values) at bits [i*3 +: 3].
REQ-009 alu_a, alu_b  output  N each  registered operands driven to the alu.
REQ-010 alu_func  output  3  registered function code driven to the alu.
REQ-011 alu_result  input  N  combinational result from the alu.
REQ-012 alu_zf  input  1  zero flag from the alu.
REQ-013 rsp_valid  output  2  bit i = response for requester i is available (one-hot or zero).
REQ-014 rsp_ready  input  2  bit i = requester i consumes its response.
REQ-015 rsp_result  output  N  registered result of the completed operation.
REQ-016 rsp_zf  output  1  registered zero flag of the completed operation.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; exactly one active.
REQ-019 IDLE: if no req_valid bit set, remain in IDLE with req_ready = 0.
REQ-020 IDLE with a single requester valid: req_ready for that requester = 1 (combinational); on the edge, latch its a/b/func into alu_a/alu_b/alu_func, record owner, go to EXEC.
REQ-021 IDLE with both valid: grant the requester named by the priority pointer; req_ready for the other requester = 0.
REQ-022 The priority pointer resets to 0; on each completed response it points to the requester that was not served (round-robin).
REQ-023 EXEC lasts exactly one cycle: capture alu_result into rsp_result and alu_zf into rsp_zf; go to RESP.
REQ-024 RESP: rsp_valid[owner] = 1, other bit 0; rsp_result and rsp_zf stable until handshake.
REQ-025 RESP handshake: rsp_valid[owner] & rsp_ready[owner]; on that edge, update pointer, go to IDLE; rsp_ready of the non-owner is ignored.
REQ-026 No new request is accepted outside IDLE; req_ready = 0 in EXEC and RESP.
REQ-027 Latency: request accepted at edge T -> rsp_valid high in cycle T+2; minimum 3 cycles per operation.
REQ-028 alu_a/alu_b/alu_func hold their last granted values in EXEC, RESP and IDLE until the next grant.
REQ-029 func codes are passed through unmodified; every 3-bit code is legal; all width/overflow behaviour (e.g. RADD/RMUL truncation to N bits) is the alu's.
REQ-030 rsp_zf is taken from alu_zf; the block does not recompute it.

Reset
REQ-031 n_reset low SHALL immediately force IDLE, pointer = 0, req_ready = 0, rsp_valid = 0, rsp_result = 0, rsp_zf = 0, alu_a = 0, alu_b = 0, alu_func = 0, busy = 0.
REQ-032 Reset asserted mid-operation (EXEC or RESP) SHALL discard the transaction with no response issued after reset release.
REQ-033 First grant after reset release occurs no earlier than the first rising edge with n_reset high.

Verification
REQ-034 Req0 only, a=5, b=17, func=RADD -> req_ready[0] same cycle, rsp_valid=2'b01 two cycles later, rsp_result=22, rsp_zf=0.
REQ-035 Both valid after reset, req0 RSUB 17,17; req1 RAND 5,17 -> req0 served first (rsp_result=0, rsp_zf=1), then req1 (rsp_result=1, rsp_zf=0).
REQ-036 Both valid continuously over 4 operations -> grants alternate 0,1,0,1; no requester starves.
REQ-037 rsp_ready[0] held low 3 cycles in RESP with req1 valid -> rsp_valid[0] and rsp_result held, req_ready[1] stays 0 until handshake.
REQ-038 n_reset pulsed low during EXEC of req1 RMUL 5,17 -> all outputs zero at once, no rsp_valid after release, next grant goes to requester 0.
